// File: rtl/sram_burst_reader_pkg.sv
// Shared definitions for the SRAM burst reader: FSM encoding, skid-buffer
// depth and the occupancy projection used by the read-issue logic.
package sram_burst_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Number of words the output skid buffer can hold.
  localparam int unsigned SKID_DEPTH   = 2;
  // Width of the skid-buffer fill count (0..SKID_DEPTH).
  localparam int unsigned SKID_COUNT_W = 2;

  // Words that will be buffered or waiting on the SRAM data bus after the
  // coming edge, given this cycle's pop, capture and bus-pending outcome.
  function automatic logic [2:0] next_occupancy(
    input logic [1:0] count,
    input logic       pop,
    input logic       push,
    input logic       pending
  );
    logic [2:0] occ;
    occ = {1'b0, count} - {2'b00, pop} + {2'b00, push} + {2'b00, pending};
    return occ;
  endfunction

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry valid/ready FIFO. The head entry is a register that drives the
// stream outputs directly, so data stays stable while the consumer stalls.
// The producer must not push when the FIFO is full and no pop happens.
module stream_skid_fifo
  import sram_burst_reader_pkg::*;
#(
  parameter int unsigned WIDTH = 9
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_push,
  input  logic [WIDTH-1:0]        i_push_data,
  input  logic                    i_ready,
  output logic                    o_valid,
  output logic [WIDTH-1:0]        o_data,
  output logic [SKID_COUNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_head_data;
  logic [WIDTH-1:0] r_tail_data;
  logic             r_head_valid;
  logic             r_tail_valid;
  logic             w_pop;

  assign w_pop   = r_head_valid & i_ready;
  assign o_valid = r_head_valid;
  assign o_data  = r_head_data;
  assign o_count = {1'b0, r_head_valid} + {1'b0, r_tail_valid};

  // Head always holds the oldest word; the tail only fills when the head is occupied.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head_data  <= '0;
      r_tail_data  <= '0;
      r_head_valid <= 1'b0;
      r_tail_valid <= 1'b0;
    end else begin
      if (w_pop) begin
        if (r_tail_valid) begin
          r_head_data  <= r_tail_data;
          r_head_valid <= 1'b1;
          r_tail_valid <= i_push;
          if (i_push) begin
            r_tail_data <= i_push_data;
          end
        end else begin
          r_head_valid <= i_push;
          if (i_push) begin
            r_head_data <= i_push_data;
          end
        end
      end else if (i_push) begin
        if (!r_head_valid) begin
          r_head_data  <= i_push_data;
          r_head_valid <= 1'b1;
        end else if (!r_tail_valid) begin
          r_tail_data  <= i_push_data;
          r_tail_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sram_burst_reader.sv
// Burst reader for one port of a synchronous SRAM. Issues sequential reads,
// absorbs the one-cycle read latency and presents the words as a valid/ready
// stream at one word per cycle when the consumer never stalls.
//
// Read pipeline: an issued address sits in r_addr ("address stage"); one edge
// later its data is on sramDataIn ("bus stage"). While no new address is issued
// the SRAM keeps returning the same word, so a bus-stage word that cannot be
// captured yet simply waits there without being lost.
module sram_burst_reader
  import sram_burst_reader_pkg::*;
#(
  parameter int unsigned nrOfAddressBits = 12,
  parameter int unsigned nrOfDataBits    = 8,
  parameter int unsigned nrOfLengthBits  = 12
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       startIn,
  input  logic [nrOfAddressBits-1:0] baseAddressIn,
  input  logic [nrOfLengthBits-1:0]  burstLengthIn,
  output logic                       busyOut,
  output logic                       doneOut,
  output logic [nrOfAddressBits-1:0] sramAddressOut,
  output logic                       sramWriteEnableOut,
  input  logic [nrOfDataBits-1:0]    sramDataIn,
  output logic [nrOfDataBits-1:0]    streamDataOut,
  output logic                       streamValidOut,
  output logic                       streamLastOut,
  input  logic                       streamReadyIn
);

  state_t                      r_state;
  logic [nrOfAddressBits-1:0]  r_addr;
  logic [nrOfLengthBits-1:0]   r_issue_left;
  logic                        r_a_valid;
  logic                        r_a_last;
  logic                        r_d_valid;
  logic                        r_d_last;
  logic                        r_busy;
  logic                        r_done;

  logic                        w_fifo_valid;
  logic [nrOfDataBits:0]       w_fifo_data;
  logic [SKID_COUNT_W-1:0]     w_fifo_count;
  logic                        w_head_last;
  logic                        w_pop;
  logic                        w_capture;
  logic                        w_d_next;
  logic [2:0]                  w_occ_next;
  logic                        w_issue;

  assign sramAddressOut     = r_addr;
  assign sramWriteEnableOut = 1'b0;
  assign busyOut            = r_busy;
  assign doneOut            = r_done;
  assign streamValidOut     = w_fifo_valid;
  assign streamDataOut      = w_fifo_data[nrOfDataBits-1:0];
  assign streamLastOut      = w_fifo_data[nrOfDataBits];
  assign w_head_last        = w_fifo_data[nrOfDataBits];

  // Capture and issue decisions: a new read is only issued if every word it
  // could meet on the way into the buffer is guaranteed a free slot.
  always_comb begin
    w_pop      = w_fifo_valid & streamReadyIn;
    w_capture  = r_d_valid & ~((w_fifo_count == 2'(SKID_DEPTH)) & ~w_pop);
    w_d_next   = r_a_valid | (r_d_valid & ~w_capture);
    w_occ_next = next_occupancy(w_fifo_count, w_pop, w_capture, w_d_next);
    if (r_state == ST_READ) begin
      w_issue = (w_occ_next <= 3'(SKID_DEPTH));
    end else begin
      w_issue = 1'b0;
    end
  end

  // Burst FSM together with the address/bus pipeline tracking and status flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_issue_left <= '0;
      r_a_valid    <= 1'b0;
      r_a_last     <= 1'b0;
      r_d_valid    <= 1'b0;
      r_d_last     <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_d_valid <= w_d_next;
      if (r_a_valid) begin
        r_d_last <= r_a_last;
      end
      r_a_valid <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (startIn) begin
            if (burstLengthIn != '0) begin
              r_addr       <= baseAddressIn;
              r_issue_left <= burstLengthIn - nrOfLengthBits'(1);
              r_a_valid    <= 1'b1;
              r_a_last     <= (burstLengthIn == nrOfLengthBits'(1));
              r_busy       <= 1'b1;
              if (burstLengthIn == nrOfLengthBits'(1)) begin
                r_state <= ST_DRAIN;
              end else begin
                r_state <= ST_READ;
              end
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        ST_READ: begin
          if (w_issue) begin
            r_addr       <= r_addr + nrOfAddressBits'(1);
            r_issue_left <= r_issue_left - nrOfLengthBits'(1);
            r_a_valid    <= 1'b1;
            r_a_last     <= (r_issue_left == nrOfLengthBits'(1));
            if (r_issue_left == nrOfLengthBits'(1)) begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (w_pop && w_head_last) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  stream_skid_fifo #(
    .WIDTH (nrOfDataBits + 1)
  ) u_skid (
    .i_clk       (clock),
    .i_rst_n     (reset),
    .i_push      (w_capture),
    .i_push_data ({r_d_last, sramDataIn}),
    .i_ready     (streamReadyIn),
    .o_valid     (w_fifo_valid),
    .o_data      (w_fifo_data),
    .o_count     (w_fifo_count)
  );

endmodule

// File: doc/sram_burst_reader.md
Name: sram_burst_reader

Overview:
- Read-side companion to the team's dual-port synchronous SRAM. It drives one SRAM port as a pure reader and turns a burst request into a valid/ready stream.
- A burst request is a base address plus a word count. The block issues sequential reads, absorbs the SRAM's 1-cycle read latency, and honours downstream backpressure at full throughput.
- It sits between the SRAM port and any stream consumer, for example a DMA or a display fetch.

Parameters:
- nrOfAddressBits, 12, SRAM address width
- nrOfDataBits, 8, SRAM word width
- nrOfLengthBits, 12, width of the burst word-count field

Ports:
- clock  input  1  single clock for all logic
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- startIn  input  1  request strobe; sampled only when idle
- baseAddressIn  input  nrOfAddressBits  first word address, sampled with startIn
- burstLengthIn  input  nrOfLengthBits  number of words to read, sampled with startIn
- busyOut  output  1  high from the cycle after an accepted start until doneOut
- doneOut  output  1  one-cycle pulse when a burst completes
- sramAddressOut  output  nrOfAddressBits  to the SRAM port address input
- sramWriteEnableOut  output  1  tied to constant 0
- sramDataIn  input  nrOfDataBits  from the SRAM port data output; valid the cycle after an address is presented
- streamDataOut  output  nrOfDataBits  stream word
- streamValidOut  output  1  stream word valid
- streamLastOut  output  1  marks the final word of a burst; qualified by streamValidOut
- streamReadyIn  input  1  consumer accepts the word when streamValidOut and streamReadyIn are both 1

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; busyOut=0, doneOut=0, streamValidOut=0, streamLastOut=0.
  - sramAddressOut=0, streamDataOut=0.
  - Buffer and in-flight tracking are cleared.
- Reset asserted mid-burst: the burst is abandoned, any in-flight SRAM data is discarded, and no doneOut pulse is produced.
- FSM states:
  - IDLE:
    - startIn=1 and burstLengthIn>0: latch base and length, set sramAddressOut=base, go to READ.
    - startIn=1 and burstLengthIn==0: stay in IDLE, pulse doneOut on the next cycle, busyOut stays 0, no stream output.
  - READ: issues reads. When the last read has been issued, go to DRAIN.
  - DRAIN: waits until the final word is handshaked, then pulses doneOut for 1 cycle and returns to IDLE.
- startIn is ignored in every state except IDLE.
- Read issue and flow control:
  - An "issue" is a cycle in which sramAddressOut holds a new, not-yet-read address that is counted as in-flight.
  - The SRAM registers its address every cycle; when the block is not issuing, the address is held and the returned data is ignored.
  - Output is a 2-entry FIFO (skid buffer). occupancy = buffered entries + in-flight read (range 0..2).
  - An issue is allowed when occupancy<2, or when occupancy==2 and a stream handshake happens in the same cycle.
  - This gives 1 word per cycle when streamReadyIn stays 1. No word is ever dropped or duplicated under any ready pattern.
- Addresses increment by 1 per issue and wrap modulo 2^nrOfAddressBits (0xFFF -> 0x000 at the default width).
- Latency:
  - start sampled at edge E0; first address presented after E0.
  - SRAM data appears after E1 and is captured into the buffer at E2.
  - streamValidOut=1 from after E2, i.e. the first word is valid 2 cycles after the start edge.
- Stream ordering: words leave strictly in address order. streamLastOut=1 only on word number burstLength-1.
- streamDataOut and streamLastOut hold stable while streamValidOut=1 and streamReadyIn=0.
- doneOut is asserted the cycle after the last handshake. busyOut falls in that same cycle, so a new start can be accepted in the cycle of doneOut.
- Maximum burst is 2^nrOfLengthBits-1 words.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE, READ, DRAIN).
  - The skid-buffer depth constant (2).
- One natural sub-module: stream_skid_fifo, a 2-entry FIFO with valid/ready, reusable by other stream blocks.

Test Plan:
- Start with base=0x010, length=4, ready held at 1 -> words mem[0x10..0x13] on 4 consecutive cycles starting 2 cycles after the start edge; last on the 4th word; doneOut one cycle later.
- Base=0xFFE, length=4 -> addresses 0xFFE, 0xFFF, 0x000, 0x001 in that order.
- Length=8 with ready toggling 1,0,0,1,0,1,... -> exactly 8 words, in order, no duplicates; data and last stable while stalled; occupancy never exceeds 2.
- Length=0 -> doneOut pulse the next cycle; streamValidOut stays 0; busyOut stays 0.
- Second startIn pulsed while busy -> ignored; only the first burst's words appear.
- reset=0 applied mid-burst after 3 of 10 words -> all outputs 0 immediately; after release, no stray valid and no done; a new burst then completes correctly.
